// File: rtl/breakout_pkg.sv
// Shared types and geometry for the Breakout frame sequencer.
//   game_state_t : sequencer state, published on game_state
//   Wall / paddle constants : play-area limits, in pixels
//   BRICK_L/T/W/H : brick table, spans inclusive [L, L+W-1] x [T, T+H-1]
//   paddle_step() : one frame of paddle motion with clamping
package breakout_pkg;

  typedef enum logic [2:0] {
    SERVE  = 3'd0,
    PLAY   = 3'd1,
    MOVE   = 3'd2,
    SCAN   = 3'd3,
    COMMIT = 3'd4,
    OVER   = 3'd5,
    WIN    = 3'd6
  } game_state_t;

  localparam int NUM_BRICKS     = 12;
  localparam int WALL_L         = 40;
  localparam int WALL_R         = 589;
  localparam int WALL_T         = 30;
  localparam int FLOOR_Y        = 479;
  localparam int PADDLE_TOP     = 440;
  localparam int PADDLE_RESET_X = 283;

  localparam logic [9:0] BRICK_L [NUM_BRICKS] = '{
    10'd40, 10'd140, 10'd240, 10'd340, 10'd440, 10'd540,
    10'd40, 10'd90,  10'd190, 10'd290, 10'd390, 10'd490
  };
  localparam logic [9:0] BRICK_T [NUM_BRICKS] = '{
    10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100,
    10'd150, 10'd150, 10'd150, 10'd150, 10'd150, 10'd150
  };
  localparam logic [9:0] BRICK_W [NUM_BRICKS] = '{
    10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd50,
    10'd50,  10'd100, 10'd100, 10'd100, 10'd100, 10'd100
  };
  localparam logic [9:0] BRICK_H [NUM_BRICKS] = '{
    10'd30, 10'd30, 10'd30, 10'd30, 10'd30, 10'd30,
    10'd30, 10'd30, 10'd30, 10'd30, 10'd30, 10'd30
  };

  // Exactly one of left/right moves the paddle; result stays in [WALL_L, max_x].
  function automatic logic [9:0] paddle_step(input logic [9:0] p, input logic l,
                                             input logic r, input int step,
                                             input int max_x);
    int q;
    q = int'(p);
    if (l && !r)
      q = (q - step < WALL_L) ? WALL_L : q - step;
    else if (r && !l)
      q = (q + step > max_x) ? max_x : q + step;
    return 10'(q);
  endfunction

endpackage

// File: rtl/breakout_game_seq_if.sv
// Game sequencer bus: controls in, published game state out.
//   master : drives frame_tick/left/right/serve, observes the outputs
//   slave  : the sequencer side
interface breakout_game_seq_if;
  import breakout_pkg::*;

  logic        frame_tick;
  logic        left;
  logic        right;
  logic        serve;
  logic [9:0]  paddle_x;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [11:0] brick_alive;
  logic [3:0]  score;
  logic [1:0]  lives;
  game_state_t game_state;
  logic        busy;
  logic        overrun;

  modport master (
    output frame_tick, left, right, serve,
    input  paddle_x, ball_x, ball_y, brick_alive, score, lives, game_state, busy, overrun
  );

  modport slave (
    input  frame_tick, left, right, serve,
    output paddle_x, ball_x, ball_y, brick_alive, score, lives, game_state, busy, overrun
  );
endinterface

// File: rtl/breakout_game_seq_overlap.sv
// brick_overlap: combinational test of the ball box [box_x, box_x+BALL_SIZE-1] x
// [box_y, box_y+BALL_SIZE-1] against brick idx of the table. Aliveness is not
// considered here.
//   idx   in  4   brick index 0..11
//   box_x in  11  ball box left column (signed)
//   box_y in  11  ball box top row (signed)
//   hit   out 1   boxes overlap
module brick_overlap
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE = 8
) (
  input  logic [3:0]         idx,
  input  logic signed [10:0] box_x,
  input  logic signed [10:0] box_y,
  output logic               hit
);

  int l, t, r, b, x, y;

  always_comb begin
    l   = int'(BRICK_L[idx]);
    t   = int'(BRICK_T[idx]);
    r   = l + int'(BRICK_W[idx]) - 1;
    b   = t + int'(BRICK_H[idx]) - 1;
    x   = int'(box_x);
    y   = int'(box_y);
    hit = (x <= r) && (x + BALL_SIZE - 1 >= l) &&
          (y <= b) && (y + BALL_SIZE - 1 >= t);
  end

endmodule

// File: rtl/breakout_game_seq.sv
// breakout_game_seq: per-frame Breakout sequencer. One update per frame_tick:
// MOVE (1 cycle) -> SCAN (12 cycles, one brick each through a shared checker)
// -> COMMIT (1 cycle). Positions are published only at COMMIT so the renderers
// never see a half-updated frame.
//   CLOCK_50 in  1   system clock
//   reset_n  in  1   asynchronous active-low reset
//   bus      slave: frame_tick/left/right/serve in; paddle_x, ball_x, ball_y,
//            brick_alive, score, lives, game_state, busy, overrun out
module breakout_game_seq
  import breakout_pkg::*;
#(
  parameter int BALL_SPEED  = 2,
  parameter int PADDLE_STEP = 5,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 64,
  parameter int START_LIVES = 3
) (
  input logic               CLOCK_50,
  input logic               reset_n,
  breakout_game_seq_if.slave bus
);

  localparam int PADDLE_MAX = WALL_R + 1 - PADDLE_W;
  localparam int SERVE_OFS  = (PADDLE_W - BALL_SIZE) / 2;
  localparam int REST_Y     = PADDLE_TOP - BALL_SIZE;
  localparam int RIGHT_STOP = WALL_R + 1 - BALL_SIZE;

  localparam logic [9:0]         PADDLE_INIT = 10'(PADDLE_RESET_X);
  localparam logic [9:0]         BALL_INIT_X = 10'(PADDLE_RESET_X + SERVE_OFS);
  localparam logic [9:0]         BALL_INIT_Y = 10'(REST_Y);
  localparam logic [1:0]         LIVES_INIT  = 2'(START_LIVES);
  localparam logic signed [10:0] SPD         = 11'(BALL_SPEED);
  localparam logic [3:0]         LAST_IDX    = 4'(NUM_BRICKS - 1);

  game_state_t state;
  logic [9:0]  paddle_x, paddle_nx, ball_x, ball_y;
  logic [11:0] brick_alive;
  logic [3:0]  score;
  logic [1:0]  lives;
  logic        busy, overrun;
  logic        vx_neg, vy_neg, hit_taken;
  logic [3:0]  idx;
  logic signed [10:0] nx, ny;

  logic [9:0]         paddle_cmd;
  logic signed [10:0] mx, my;
  logic               hit;
  int                 cx, cy;
  logic               cvx_neg, cvy_neg, miss;

  always_comb paddle_cmd = paddle_step(paddle_x, bus.left, bus.right, PADDLE_STEP, PADDLE_MAX);

  always_comb begin
    mx = signed'({1'b0, ball_x}) + (vx_neg ? -SPD : SPD);
    my = signed'({1'b0, ball_y}) + (vy_neg ? -SPD : SPD);
  end

  brick_overlap #(.BALL_SIZE(BALL_SIZE)) u_overlap (
    .idx   (idx),
    .box_x (nx),
    .box_y (ny),
    .hit   (hit)
  );

  // Wall and paddle reflections on the post-scan position; the paddle test
  // uses the paddle position computed this frame (paddle_nx).
  always_comb begin
    cx      = int'(nx);
    cy      = int'(ny);
    cvx_neg = vx_neg;
    cvy_neg = vy_neg;
    if (cx < WALL_L) begin
      cx      = WALL_L;
      cvx_neg = 1'b0;
    end
    if (cx + BALL_SIZE - 1 > WALL_R) begin
      cx      = RIGHT_STOP;
      cvx_neg = 1'b1;
    end
    if (cy < WALL_T) begin
      cy      = WALL_T;
      cvy_neg = 1'b0;
    end
    if (!cvy_neg &&
        (int'(ball_y) + BALL_SIZE - 1 < PADDLE_TOP) &&
        (cy + BALL_SIZE - 1 >= PADDLE_TOP) &&
        (cx <= int'(paddle_nx) + PADDLE_W - 1) &&
        (cx + BALL_SIZE - 1 >= int'(paddle_nx))) begin
      cy      = REST_Y;
      cvy_neg = 1'b1;
    end
    miss = (cy > FLOOR_Y);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SERVE;
      paddle_x    <= PADDLE_INIT;
      paddle_nx   <= PADDLE_INIT;
      ball_x      <= BALL_INIT_X;
      ball_y      <= BALL_INIT_Y;
      brick_alive <= '1;
      score       <= '0;
      lives       <= LIVES_INIT;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      vx_neg      <= 1'b0;
      vy_neg      <= 1'b1;
      hit_taken   <= 1'b0;
      idx         <= '0;
      nx          <= '0;
      ny          <= '0;
    end else begin
      if (bus.frame_tick && busy)
        overrun <= 1'b1;

      case (state)
        SERVE: begin
          if (bus.serve) begin
            state  <= PLAY;
            vx_neg <= 1'b0;
            vy_neg <= 1'b1;
          end else if (bus.frame_tick) begin
            paddle_x  <= paddle_cmd;
            paddle_nx <= paddle_cmd;
            ball_x    <= paddle_cmd + 10'(SERVE_OFS);
            ball_y    <= BALL_INIT_Y;
          end
        end

        PLAY: begin
          if (bus.frame_tick) begin
            state <= MOVE;
            busy  <= 1'b1;
          end
        end

        // Paddle result is held privately until COMMIT publishes it.
        MOVE: begin
          paddle_nx <= paddle_cmd;
          nx        <= mx;
          ny        <= my;
          idx       <= '0;
          hit_taken <= 1'b0;
          state     <= SCAN;
        end

        SCAN: begin
          if (!hit_taken && brick_alive[idx] && hit) begin
            brick_alive[idx] <= 1'b0;
            score            <= score + 4'd1;
            vy_neg           <= ~vy_neg;
            ny               <= signed'({1'b0, ball_y});
            hit_taken        <= 1'b1;
          end
          if (idx == LAST_IDX)
            state <= COMMIT;
          else
            idx <= idx + 4'd1;
        end

        COMMIT: begin
          paddle_x <= paddle_nx;
          ball_x   <= 10'(cx);
          ball_y   <= 10'(cy);
          vx_neg   <= cvx_neg;
          vy_neg   <= cvy_neg;
          busy     <= 1'b0;
          if (brick_alive == '0)
            state <= WIN;
          else if (miss) begin
            lives <= lives - 2'd1;
            state <= (lives == 2'd1) ? OVER : SERVE;
          end else
            state <= PLAY;
        end

        OVER, WIN: begin
          if (bus.serve) begin
            brick_alive <= '1;
            score       <= '0;
            lives       <= LIVES_INIT;
            paddle_x    <= PADDLE_INIT;
            paddle_nx   <= PADDLE_INIT;
            state       <= SERVE;
          end
        end

        default: state <= SERVE;
      endcase
    end
  end

  assign bus.paddle_x    = paddle_x;
  assign bus.ball_x      = ball_x;
  assign bus.ball_y      = ball_y;
  assign bus.brick_alive = brick_alive;
  assign bus.score       = score;
  assign bus.lives       = lives;
  assign bus.game_state  = state;
  assign bus.busy        = busy;
  assign bus.overrun     = overrun;

endmodule

// File: tb/tb_breakout_game_seq.sv
// Self-checking bench for breakout_game_seq: constant reset/paddle tables,
// hand-written serve/overrun/reset sequences and a randomized game checked
// against a frame-level reference model.
module tb_breakout_game_seq;
  import breakout_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  breakout_game_seq_if bus();

  breakout_game_seq #(
    .BALL_SPEED  (2),
    .PADDLE_STEP (5),
    .BALL_SIZE   (8),
    .PADDLE_W    (64),
    .START_LIVES (3)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_px, m_bx, m_by, m_vx, m_vy, m_score, m_lives;
  logic [11:0] m_alive;
  game_state_t m_state;
  bit          m_overrun;

  int bl [12] = '{40, 140, 240, 340, 440, 540, 40, 90, 190, 290, 390, 490};
  int bw [12] = '{100, 100, 100, 100, 100, 50, 50, 100, 100, 100, 100, 100};

  typedef struct {
    bit l;
    bit r;
    int n;
    int exp_px;
  } pad_vec_t;
  pad_vec_t pad_vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".paddle_x"},    int'(bus.paddle_x),    m_px);
    check({tag, ".ball_x"},      int'(bus.ball_x),      m_bx);
    check({tag, ".ball_y"},      int'(bus.ball_y),      m_by);
    check({tag, ".brick_alive"}, int'(bus.brick_alive), int'(m_alive));
    check({tag, ".score"},       int'(bus.score),       m_score);
    check({tag, ".lives"},       int'(bus.lives),       m_lives);
    check({tag, ".game_state"},  int'(bus.game_state),  int'(m_state));
    check({tag, ".busy"},        int'(bus.busy),        0);
    check({tag, ".overrun"},     int'(bus.overrun),     int'(m_overrun));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".paddle_x"},    int'(bus.paddle_x),    283);
    check({tag, ".ball_x"},      int'(bus.ball_x),      311);
    check({tag, ".ball_y"},      int'(bus.ball_y),      432);
    check({tag, ".brick_alive"}, int'(bus.brick_alive), 'hFFF);
    check({tag, ".score"},       int'(bus.score),       0);
    check({tag, ".lives"},       int'(bus.lives),       3);
    check({tag, ".game_state"},  int'(bus.game_state),  0);
    check({tag, ".busy"},        int'(bus.busy),        0);
    check({tag, ".overrun"},     int'(bus.overrun),     0);
  endtask

  function automatic int step(input int p, input bit l, input bit r);
    if (l && !r) return (p - 5 < 40) ? 40 : p - 5;
    if (r && !l) return (p + 5 > 526) ? 526 : p + 5;
    return p;
  endfunction

  task automatic model_reset();
    m_px = 283; m_bx = 311; m_by = 432;
    m_vx = 2;   m_vy = -2;
    m_alive = 12'hFFF; m_score = 0; m_lives = 3;
    m_state = SERVE; m_overrun = 0;
  endtask

  task automatic model_serve();
    if (m_state == SERVE) begin
      m_state = PLAY; m_vx = 2; m_vy = -2;
    end else if (m_state == OVER || m_state == WIN) begin
      m_alive = 12'hFFF; m_score = 0; m_lives = 3; m_px = 283; m_state = SERVE;
    end
  endtask

  task automatic model_tick(input bit l, input bit r);
    int nx, ny;
    if (m_state == SERVE) begin
      m_px = step(m_px, l, r);
      m_bx = m_px + 28;
      m_by = 432;
    end else if (m_state == PLAY) begin
      m_px = step(m_px, l, r);
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      for (int i = 0; i < 12; i++) begin
        int t;
        t = (i < 6) ? 100 : 150;
        if (m_alive[i] && nx <= bl[i] + bw[i] - 1 && nx + 7 >= bl[i] &&
            ny <= t + 29 && ny + 7 >= t) begin
          m_alive[i] = 1'b0;
          m_score++;
          m_vy = -m_vy;
          ny = m_by;
          break;
        end
      end
      if (nx < 40)      begin nx = 40;  m_vx = 2;  end
      if (nx + 7 > 589) begin nx = 582; m_vx = -2; end
      if (ny < 30)      begin ny = 30;  m_vy = 2;  end
      if (m_vy > 0 && m_by + 7 < 440 && ny + 7 >= 440 &&
          nx <= m_px + 63 && nx + 7 >= m_px) begin
        ny = 432; m_vy = -2;
      end
      m_bx = nx;
      m_by = ny;
      if (m_alive == 12'h000) m_state = WIN;
      else if (ny > 479) begin
        m_lives--;
        m_state = (m_lives == 0) ? OVER : SERVE;
      end else m_state = PLAY;
    end
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.serve = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse_serve();
    @(posedge clk); #1 bus.serve = 1'b1;
    @(posedge clk); #1 bus.serve = 1'b0;
    model_serve();
  endtask

  // One frame tick. From PLAY the result must appear exactly 14 clocks after the
  // tick edge; positions must not move before then. Optionally a second tick
  // (5 cycles after the first) and/or a serve pulse land mid-update.
  task automatic run_frame(input bit l, input bit r, input bit serve_mid,
                           input bit dbl, input string tag);
    game_state_t st0;
    int old_bx, old_by, old_px;
    st0 = m_state; old_bx = m_bx; old_by = m_by; old_px = m_px;
    bus.left = l; bus.right = r;
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    if (st0 == PLAY) begin
      check({tag, ".busy_start"}, int'(bus.busy), 1);
      for (int c = 1; c <= 14; c++) begin
        @(posedge clk); #1;
        if (c == 4) begin
          bus.frame_tick = dbl; bus.serve = serve_mid;
        end else begin
          bus.frame_tick = 1'b0; bus.serve = 1'b0;
        end
        if (c == 13) begin
          check({tag, ".busy_c13"},   int'(bus.busy),     1);
          check({tag, ".hold_bx"},    int'(bus.ball_x),   old_bx);
          check({tag, ".hold_by"},    int'(bus.ball_y),   old_by);
          check({tag, ".hold_px"},    int'(bus.paddle_x), old_px);
        end
      end
      if (dbl) m_overrun = 1'b1;
    end
    model_tick(l, r);
    check_all(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pad_vecs[0] = '{0, 0, 1,   283};
    pad_vecs[1] = '{1, 1, 1,   283};
    pad_vecs[2] = '{0, 1, 1,   288};
    pad_vecs[3] = '{1, 0, 2,   278};
    pad_vecs[4] = '{1, 0, 60,  40};
    pad_vecs[5] = '{1, 0, 3,   40};
    pad_vecs[6] = '{0, 1, 100, 526};
    pad_vecs[7] = '{1, 1, 2,   526};
    pad_vecs[8] = '{0, 1, 1,   526};
    pad_vecs[9] = '{1, 0, 1,   521};

    // Reset values
    do_reset();
    #1 check_reset_values("reset");

    // Serve with no buttons, first frame
    pulse_serve();
    check("serve.state", int'(bus.game_state), int'(PLAY));
    run_frame(0, 0, 0, 0, "first");
    check("first.ball_x", int'(bus.ball_x), 313);
    check("first.ball_y", int'(bus.ball_y), 430);

    // Second tick 5 cycles after the first is dropped and flags overrun
    run_frame(0, 1, 0, 1, "dbl");
    check("dbl.overrun", int'(bus.overrun), 1);

    // Reset asserted mid-SCAN takes effect immediately
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_values("midscan_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Paddle table in SERVE: direction, both/neither, clamps
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < pad_vecs[i].n; k++)
        run_frame(pad_vecs[i].l, pad_vecs[i].r, 0, 0, "pad");
      check("pad_tbl.paddle_x", int'(bus.paddle_x), pad_vecs[i].exp_px);
      check("pad_tbl.ball_x",   int'(bus.ball_x),   pad_vecs[i].exp_px + 28);
      check("pad_tbl.ball_y",   int'(bus.ball_y),   432);
    end

    // Randomized game against the model
    do_reset();
    for (int f = 0; f < 2000; f++) begin
      bit l, r, sm;
      case (m_state)
        SERVE:     if ($urandom_range(0, 7) == 0)  pulse_serve();
        OVER, WIN: if ($urandom_range(0, 1) == 0)  pulse_serve();
        PLAY:      if ($urandom_range(0, 15) == 0) pulse_serve();
        default: ;
      endcase
      if (m_state == PLAY && $urandom_range(0, 9) < 8) begin
        l = (m_bx + 4 < m_px + 32 - 6);
        r = (m_bx + 4 > m_px + 32 + 6);
      end else begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      sm = (m_state == PLAY) && ($urandom_range(0, 15) == 0);
      run_frame(l, r, sm, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
